// File: rtl/seg7_pkg.sv
// Shared constants for the 3-digit multiplexed 7-segment display:
// active-high segment codes, digit scan indices and the settle tuple layout.
package seg7_pkg;

  // Segment codes, bit order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Scan order: units first, then tens, then hundreds
  localparam logic [1:0] IDX_U = 2'd0;
  localparam logic [1:0] IDX_T = 2'd1;
  localparam logic [1:0] IDX_H = 2'd2;

  // Everything the upstream converter presents; compared as a whole to detect settling
  typedef struct packed {
    logic [3:0] cent;
    logic [3:0] dec;
    logic [3:0] un;
    logic       c_nz;
    logic       de_nz;
  } bcd_tuple_t;

  // Anode pattern {hund,tens,units} for a scan index, active-high
  function automatic logic [2:0] idx_onehot(input logic [1:0] idx);
    case (idx)
      IDX_U:   return 3'b001;
      IDX_T:   return 3'b010;
      IDX_H:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to 7-segment decoder, active-high outputs.
// Non-BCD codes show a dash so a corrupted digit is visible rather than blank.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Table lookup of the segment pattern
  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// 3-digit multiplexed 7-segment driver fed by a binary-to-BCD stage.
// A value is captured only once the upstream tuple has been stable for two
// consecutive DONE cycles, so intermediate conversion steps never reach the
// display; the captured value is held while DONE is low.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       DONE,
  input  logic [3:0] centenas,
  input  logic [3:0] decenas,
  input  logic [3:0] unidades,
  input  logic       C,
  input  logic       De,
  input  logic       U,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       valid
);

  localparam int         PW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [2:0] AN_IDLE  = AN_ACTIVE_LOW ? 3'b111 : 3'b000;

  bcd_tuple_t    r_prev_t;
  bcd_tuple_t    r_shadow;
  logic          r_prev_done;
  logic          r_valid;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [6:0]    r_seg;
  logic [2:0]    r_an;

  bcd_tuple_t    w_t;
  logic          w_latch;
  logic [3:0]    w_digit;
  logic          w_en;
  logic [6:0]    w_dec;
  logic [6:0]    w_seg_act;
  logic [2:0]    w_an_act;
  logic          w_unused_u;

  // The units flag is informational only; units is always lit once valid
  assign w_unused_u = U;

  assign w_t     = '{cent: centenas, dec: decenas, un: unidades, c_nz: C, de_nz: De};
  assign w_latch = DONE && r_prev_done && (w_t == r_prev_t);

  // Settle detector: remember last tuple/DONE, capture when two DONE cycles agree
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_t    <= '0;
      r_prev_done <= 1'b0;
      r_shadow    <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_prev_t    <= w_t;
      r_prev_done <= DONE;
      if (w_latch) begin
        r_shadow <= w_t;
        r_valid  <= 1'b1;
      end
    end
  end

  // Refresh prescaler; each terminal count moves the scan to the next digit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= IDX_U;
    end else if (r_presc == PRESC_TC) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IDX_H) ? IDX_U : r_idx + 2'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Select the scanned digit and decide whether it is lit (leading-zero blanking);
  // tens stays lit when hundreds is non-zero so inner zeros such as 105 show
  always_comb begin
    w_digit = r_shadow.un;
    w_en    = 1'b0;
    case (r_idx)
      IDX_U: begin
        w_digit = r_shadow.un;
        w_en    = r_valid;
      end
      IDX_T: begin
        w_digit = r_shadow.dec;
        w_en    = r_valid & (r_shadow.c_nz | r_shadow.de_nz);
      end
      IDX_H: begin
        w_digit = r_shadow.cent;
        w_en    = r_valid & r_shadow.c_nz;
      end
      default: begin
        w_digit = r_shadow.un;
        w_en    = 1'b0;
      end
    endcase
  end

  seg7_decoder u_decoder (
    .i_bcd (w_digit),
    .o_seg (w_dec)
  );

  assign w_seg_act = w_en ? w_dec : SEG_OFF;
  assign w_an_act  = w_en ? idx_onehot(r_idx) : 3'b000;

  // Output register; polarity applied last so blanked digits are truly off
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= SEG_IDLE;
      r_an  <= AN_IDLE;
    end else begin
      r_seg <= SEG_ACTIVE_LOW ? ~w_seg_act : w_seg_act;
      r_an  <= AN_ACTIVE_LOW ? ~w_an_act : w_an_act;
    end
  end

  assign seg   = r_seg;
  assign an    = r_an;
  assign valid = r_valid;

endmodule
